// File: rtl/j_latch_arb_if.sv
// Host/DSP write-request bus into the shared latch-bank arbiter.
// Requesters drive the master side; the arbiter is the slave.
interface j_latch_arb_if #(
  parameter int DW   = 16,
  parameter int NREG = 8
);
  logic            h_req;
  logic [2:0]      h_addr;
  logic [DW-1:0]   h_data;
  logic            h_ack;
  logic            d_req;
  logic [2:0]      d_addr;
  logic [DW-1:0]   d_data;
  logic            d_ack;
  logic [NREG-1:0] wr_en;
  logic [DW-1:0]   wr_data;
  logic            busy;

  modport master (
    output h_req, h_addr, h_data,
    output d_req, d_addr, d_data,
    input  h_ack, d_ack,
    input  wr_en, wr_data, busy
  );

  modport slave (
    input  h_req, h_addr, h_data,
    input  d_req, d_addr, d_data,
    output h_ack, d_ack,
    output wr_en, wr_data, busy
  );
endinterface

// File: rtl/j_latch_arb.sv
// Round-robin host/DSP arbiter for a shared enable-latch bank.
// One write per two cycles; every output comes straight from a flop.
module j_latch_arb #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input logic           sys_clk,
  input logic           resetl,
  j_latch_arb_if.slave  bus
);

  typedef enum logic {IDLE, WRITE} state_t;
  typedef enum logic {GNT_H, GNT_D} who_t;

  state_t          state_q, state_d;
  who_t            last_q, last_d;
  logic [NREG-1:0] wr_en_q, wr_en_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            h_ack_q, h_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            busy_q, busy_d;

  logic            idle;
  logic            pick_h;
  logic            pick_d;

  // Grant decision: host wins alone or on its round-robin turn.
  always_comb begin
    idle   = (state_q == IDLE);
    pick_h = idle && bus.h_req &&
             (!bus.d_req || last_q == GNT_D);
    pick_d = idle && bus.d_req && !pick_h;
  end

  // Next-state and next-output for the single write slot.
  always_comb begin
    state_d   = IDLE;
    last_d    = last_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    h_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    busy_d    = 1'b0;
    unique case (1'b1)
      pick_h: begin
        state_d   = WRITE;
        last_d    = GNT_H;
        wr_en_d   = NREG'(1) << bus.h_addr;
        wr_data_d = bus.h_data;
        h_ack_d   = 1'b1;
        busy_d    = 1'b1;
      end
      pick_d: begin
        state_d   = WRITE;
        last_d    = GNT_D;
        wr_en_d   = NREG'(1) << bus.d_addr;
        wr_data_d = bus.d_data;
        d_ack_d   = 1'b1;
        busy_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM and registered outputs; reset aborts any write in flight.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q   <= IDLE;
      last_q    <= GNT_D;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      h_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      h_ack_q   <= h_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.h_ack   = h_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.busy    = busy_q;

endmodule
